// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//  - state_e : 3-bit controller state encoding
//  - Ctl*    : bit positions of the pipeline control vector and the
//              canned control patterns the controller selects between
package pipeline_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRun     = 3'd1,
      StMemWait = 3'd2,
      StMemDone = 3'd3,
      StError   = 3'd4
   } state_e;

   localparam int unsigned CtlW           = 6;
   localparam int unsigned CtlPcWrite     = 0;
   localparam int unsigned CtlIfidWrite   = 1;
   localparam int unsigned CtlIfidFlush   = 2;
   localparam int unsigned CtlIdexBubble  = 3;
   localparam int unsigned CtlExmemWrite  = 4;
   localparam int unsigned CtlMemwbBubble = 5;

   // Pipeline frozen, nothing injected (IDLE, ERROR).
   localparam logic [CtlW-1:0] CtlFrozen    = 6'b000000;
   // Frozen while MEM is busy; a NOP is pushed into MEM/WB.
   localparam logic [CtlW-1:0] CtlFreezeMem = 6'b100000;
   // Front end held, bubble into ID/EX, back end keeps draining.
   localparam logic [CtlW-1:0] CtlLoadUse   = 6'b011000;
   // Redirect: PC and IF/ID advance but the fetched instruction is squashed.
   localparam logic [CtlW-1:0] CtlBranch    = 6'b010111;
   localparam logic [CtlW-1:0] CtlAllEn     = 6'b010011;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter.
//  clk_i   : clock
//  rst_ni  : asynchronous active-low reset, clears the count
//  clear_i : synchronous clear
//  inc_i   : add one this cycle unless already at all-ones
//  count_o : current count
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges load-use stalls,
// ID-stage taken branches and a multi-cycle data-memory req/ack handshake into the
// pipeline-register enables, bubbles and flushes.
//  clk_i, rst_i            : clock, asynchronous active-low reset
//  start_i                 : leave IDLE
//  LoadUse_i               : load-use stall request
//  BranchTaken_i           : branch resolved taken in ID
//  MemAccess_MEM_i         : MEM-stage instruction is a load/store
//  mem_ack_i               : data memory finished the access
//  mem_req_o               : registered data memory request
//  PCWrite_o .. MEMWB_Bubble_o : pipeline control, combinational from state/inputs
//  Timeout_o               : sticky memory-timeout flag
//  StallCnt_o              : saturating count of stalled (PCWrite_o=0) cycles outside IDLE
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             LoadUse_i,
   input  logic             BranchTaken_i,
   input  logic             MemAccess_MEM_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             PCWrite_o,
   output logic             IFID_Write_o,
   output logic             IFID_Flush_o,
   output logic             IDEX_Bubble_o,
   output logic             EXMEM_Write_o,
   output logic             MEMWB_Bubble_o,
   output logic             Timeout_o,
   output logic [CNT_W-1:0] StallCnt_o
);

   // Wait counter only ever needs to reach TIMEOUT-1.
   localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic             mem_req_q;
   logic             timeout_q;
   logic [CtlW-1:0]  ctl;
   logic             wait_expired;
   logic             stall_inc;

   assign wait_expired = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      ctl     = CtlFrozen;
      unique case (state_q)
         StIdle: begin
            if (start_i) state_d = StRun;
         end
         StRun: begin
            if (MemAccess_MEM_i) begin
               ctl     = CtlFreezeMem;
               state_d = StMemWait;
            end else if (LoadUse_i) begin
               // Any taken branch this cycle is re-resolved once the stall clears.
               ctl = CtlLoadUse;
            end else if (BranchTaken_i) begin
               ctl = CtlBranch;
            end else begin
               ctl = CtlAllEn;
            end
         end
         StMemWait: begin
            ctl = CtlFreezeMem;
            // Ack is checked first so an ack in the last allowed cycle still completes.
            if (mem_ack_i) begin
               state_d = StMemDone;
            end else if (wait_expired) begin
               state_d = StError;
            end else if (TIMEOUT != 0) begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StMemDone: begin
            ctl     = CtlAllEn;
            state_d = StRun;
         end
         StError: begin
            ctl = CtlFrozen;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         mem_req_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_req_q <= (state_d == StMemWait);
         timeout_q <= timeout_q | (state_d == StError);
      end
   end

   assign stall_inc = ((state_q == StRun) || (state_q == StMemWait) || (state_q == StError))
                      && !ctl[CtlPcWrite];

   sat_counter #(
      .Width (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .clear_i (1'b0),
      .inc_i   (stall_inc),
      .count_o (StallCnt_o)
   );

   assign mem_req_o      = mem_req_q;
   assign Timeout_o      = timeout_q;
   assign PCWrite_o      = ctl[CtlPcWrite];
   assign IFID_Write_o   = ctl[CtlIfidWrite];
   assign IFID_Flush_o   = ctl[CtlIfidFlush];
   assign IDEX_Bubble_o  = ctl[CtlIdexBubble];
   assign EXMEM_Write_o  = ctl[CtlExmemWrite];
   assign MEMWB_Bubble_o = ctl[CtlMemwbBubble];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized episodes, all compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

   localparam int TO   = 4;
   localparam int CW   = 5;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start, lu, br, mem, ack;
   logic          mem_req, pcw, ifidw, flush, bubble, exmemw, memwbb, tout;
   logic [CW-1:0] cnt;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: what the controller is doing, in plain terms.
   bit m_started;   // left IDLE
   bit m_in_wait;   // memory access outstanding
   int m_wcnt;      // cycles already spent waiting (before this one)
   bit m_served;    // access just completed, instruction advancing
   bit m_err;       // timed out
   int m_cnt;       // stalled-cycle count

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .start_i         (start),
      .LoadUse_i       (lu),
      .BranchTaken_i   (br),
      .MemAccess_MEM_i (mem),
      .mem_ack_i       (ack),
      .mem_req_o       (mem_req),
      .PCWrite_o       (pcw),
      .IFID_Write_o    (ifidw),
      .IFID_Flush_o    (flush),
      .IDEX_Bubble_o   (bubble),
      .EXMEM_Write_o   (exmemw),
      .MEMWB_Bubble_o  (memwbb),
      .Timeout_o       (tout),
      .StallCnt_o      (cnt)
   );

   // Packed as {memwb_bubble, exmem_write, idex_bubble, ifid_flush, ifid_write, pc_write}
   function automatic logic [5:0] exp_ctl();
      if (!m_started || m_err) return 6'b000000;
      if (m_in_wait)           return 6'b100000;
      if (m_served)            return 6'b010011;
      if (mem)                 return 6'b100000;
      if (lu)                  return 6'b011000;
      if (br)                  return 6'b010111;
      return 6'b010011;
   endfunction

   task automatic model_reset();
      m_started = 0; m_in_wait = 0; m_wcnt = 0; m_served = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic compare();
      logic [5:0] e, a;
      e = exp_ctl();
      a = {memwbb, exmemw, bubble, flush, ifidw, pcw};
      vectors++;
      if (a !== e || mem_req !== m_in_wait || tout !== m_err || int'(cnt) != m_cnt) begin
         miscompares++;
         $display("FAIL cycle t=%0t: got ctl=%b req=%b to=%b cnt=%0d, expected ctl=%b req=%b to=%b cnt=%0d",
                  $time, a, mem_req, tout, cnt, e, m_in_wait, m_err, m_cnt);
      end
   endtask

   // Advance the model across the coming clock edge.
   task automatic step();
      logic [5:0] e;
      e = exp_ctl();
      if (m_started && !e[0] && m_cnt < MAXC) m_cnt++;
      if (!m_started) begin
         m_started = start;
      end else if (m_err) begin
      end else if (m_in_wait) begin
         if (ack) begin
            m_in_wait = 0; m_served = 1;
         end else if (m_wcnt == TO - 1) begin
            m_in_wait = 0; m_err = 1;
         end else begin
            m_wcnt++;
         end
      end else if (m_served) begin
         m_served = 0;
      end else if (mem) begin
         m_in_wait = 1; m_wcnt = 0;
      end
   endtask

   task automatic check_lit(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input logic s, input logic l, input logic b, input logic m,
                         input logic a);
      start = s; lu = l; br = b; mem = m; ack = a;
   endtask

   task automatic sample();
      @(negedge clk);
      compare();
      step();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      adv();
   endtask

   // Entered at posedge+1; asserts reset between edges, leaves at posedge+1.
   task automatic do_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #1 compare();
      check_lit("async_reset_req", int'(mem_req), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int req_cycles;
      set_in(0, 0, 0, 0, 0);
      model_reset();
      #2 compare();
      check_lit("reset_stallcnt", int'(cnt), 0);
      check_lit("reset_timeout", int'(tout), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Start, free-running with no hazards.
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0); tick(); tick();
      sample();
      check_lit("run_pcwrite", int'(pcw), 1);
      check_lit("run_stallcnt", int'(cnt), 0);
      adv();

      // Single load-use stall.
      set_in(0, 1, 0, 0, 0); sample();
      check_lit("lu_pcwrite", int'(pcw), 0);
      check_lit("lu_ifidwrite", int'(ifidw), 0);
      check_lit("lu_bubble", int'(bubble), 1);
      adv();
      set_in(0, 0, 0, 0, 0); sample();
      check_lit("lu_stallcnt", int'(cnt), 1);
      adv();

      // Load-use suppresses a simultaneous branch; branch alone flushes.
      set_in(0, 1, 1, 0, 0); sample();
      check_lit("lu_br_flush", int'(flush), 0);
      check_lit("lu_br_pcwrite", int'(pcw), 0);
      adv();
      set_in(0, 0, 1, 0, 0); sample();
      check_lit("br_flush", int'(flush), 1);
      check_lit("br_pcwrite", int'(pcw), 1);
      adv();

      // Memory access acked in the third wait cycle.
      do_reset();
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 1, 0); sample();
      check_lit("mem_detect_req", int'(mem_req), 0);
      adv();
      req_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, (i == 2));
         sample();
         req_cycles += int'(mem_req);
         adv();
      end
      set_in(0, 1, 1, 1, 0); sample();
      req_cycles += int'(mem_req);
      check_lit("mem_req_cycles", req_cycles, 3);
      check_lit("mem_done_enables", int'(pcw & ifidw & exmemw), 1);
      check_lit("mem_done_stallcnt", int'(cnt), 4);
      adv();
      set_in(0, 0, 0, 0, 1); sample();
      check_lit("mem_back_in_run", int'(pcw), 1);
      adv();

      // Never acked: timeout after four wait cycles, then frozen.
      set_in(0, 0, 0, 1, 0); tick();
      set_in(0, 0, 0, 0, 0);
      for (int i = 0; i < TO; i++) tick();
      sample();
      check_lit("to_flag", int'(tout), 1);
      check_lit("to_req", int'(mem_req), 0);
      check_lit("to_stallcnt", int'(cnt), 9);
      adv();
      for (int i = 0; i < 30; i++) begin
         set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick();
      end
      sample();
      check_lit("err_saturated", int'(cnt), MAXC);
      check_lit("err_frozen", int'(pcw), 0);
      adv();

      // Reset while waiting on memory.
      do_reset();
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 1, 0); tick();
      set_in(0, 0, 0, 0, 0);
      check_lit("wait_req_high", int'(mem_req), 1);
      do_reset();
      sample();
      check_lit("post_reset_idle", int'(pcw), 0);
      adv();

      // Randomized episodes.
      for (int ep = 0; ep < 6; ep++) begin
         do_reset();
         for (int c = 0; c < 200; c++) begin
            set_in(($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 2) == 0));
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
